// File: rtl/bus_grant_sequencer_if.sv
// Handshake bundle between a mask producer, the grant sequencer
// and the bus-select encoder that consumes the one-hot grant.
interface bus_grant_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] req_mask;
  logic             abort;
  logic             accept;
  logic [WIDTH-1:0] grant_onehot;
  logic             grant_valid;
  logic             busy;
  logic             done;
  logic             timeout_err;

  modport master (
    output start,
    output req_mask,
    output abort,
    output accept,
    input  grant_onehot,
    input  grant_valid,
    input  busy,
    input  done,
    input  timeout_err
  );

  modport slave (
    input  start,
    input  req_mask,
    input  abort,
    input  accept,
    output grant_onehot,
    output grant_valid,
    output busy,
    output done,
    output timeout_err
  );
endinterface

// File: rtl/bus_grant_sequencer.sv
// One-hot grant sequencer: walks a request mask lowest bit first.
// Define GRANT_TIMEOUT_EN to add a sticky accept-timeout error.
module bus_grant_sequencer #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  bus_grant_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_d;
  logic [WIDTH-1:0] low;
  logic             gnt;
  logic             tmo_hit;

  // two's-complement trick isolates the lowest pending source
  assign low = pend_q & (-pend_q);
  assign gnt = (state_q == S_GRANT);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (|bus.req_mask) begin
            pend_d  = bus.req_mask;
            state_d = S_GRANT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GRANT: begin
        if (bus.abort) begin
          pend_d  = '0;
          state_d = S_IDLE;
        end else if (bus.accept) begin
          pend_d = pend_q & ~low;
          if (~|pend_d) begin
            state_d = S_DONE;
          end
        end else if (tmo_hit) begin
          pend_d  = '0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = '0;
      end
    endcase
  end

  assign bus.grant_valid  = gnt;
  assign bus.grant_onehot = {WIDTH{gnt}} & low;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);

`ifdef GRANT_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_q;
  logic          err_q;

  // accept and abort both outrank the limit in the same cycle
  assign tmo_hit = gnt && !bus.accept && !bus.abort &&
                   (wait_q == LIM);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!gnt || bus.accept || bus.abort || tmo_hit) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_q + CW'(1);
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo      = (TIMEOUT_CYCLES != 0);
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// Scoreboard bench for bus_grant_sequencer: the driver queues the
// expected grant stream, a monitor pops and compares it.
module tb_bus_grant_sequencer;
  localparam int W = 32;
  localparam int K_GRANT = 0;
  localparam int K_ABORT = 1;
  localparam int K_TMO   = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int           kind;
    logic [W-1:0] val;
    int           hold;
  } tok_t;

  logic clk;
  logic clr_n;
  int   n_cmp;
  int   n_bad;
  bit   exp_tmo;
  tok_t q[$];

  bus_grant_sequencer_if #(.WIDTH(W)) bus ();

  bus_grant_sequencer #(
    .WIDTH(W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    bit   st_seen;
    int   gv_cnt;
    tok_t t;
    st_seen = 0;
    gv_cnt  = 0;
    forever begin
      @(negedge clk);
      #3;
      if (!clr_n) begin
        st_seen = 0;
        gv_cnt  = 0;
      end else begin
        if (bus.grant_valid)
          chk("onehot", 64'($onehot(bus.grant_onehot)), 1);
        else
          chk("grant_zero", bus.grant_onehot, 0);
        chk("timeout_err", bus.timeout_err, exp_tmo);
        if (st_seen) chk("start_latency", bus.busy, 1);
        if (bus.grant_valid) begin
          gv_cnt++;
          if (q.size() == 0 || q[0].kind == K_DONE) begin
            chk("unexpected_grant", bus.grant_onehot, 0);
          end else begin
            t = q[0];
            chk("grant_value", bus.grant_onehot, t.val);
            if (t.kind == K_GRANT && bus.accept && !bus.abort) begin
              void'(q.pop_front());
            end else if (t.kind == K_ABORT && bus.abort) begin
              void'(q.pop_front());
            end else if (t.kind == K_TMO) begin
              t.hold--;
              q[0] = t;
              if (t.hold == 0) begin
                void'(q.pop_front());
                exp_tmo = 1;
              end
            end
          end
        end
        if (bus.done) begin
          chk("done_expected",
              64'(q.size() != 0 && q[0].kind == K_DONE), 1);
          if (q.size() != 0 && q[0].kind == K_DONE) begin
            if (q[0].hold >= 0)
              chk("grant_cycles", gv_cnt, q[0].hold);
            void'(q.pop_front());
          end
        end
        st_seen = bus.start && !bus.busy;
        if (st_seen) gv_cnt = 0;
      end
    end
  end

  task automatic run_seq(input logic [W-1:0] mask, input bit all_acc,
                         input int stall0, input bit poke,
                         input int ab_idx, input bit ab_acc,
                         input int to_idx);
    int           pos[$];
    int           n;
    int           k;
    int           st;
    int           lows;
    int           cyc;
    bit           fin;
    tok_t         t;
    logic [W-1:0] one;
    one = {{(W-1){1'b0}}, 1'b1};
    for (int i = 0; i < W; i++)
      if (mask[i]) pos.push_back(i);
    n   = pos.size();
    fin = 0;
    for (int j = 0; j < n && !fin; j++) begin
      t.val  = one << pos[j];
      t.hold = 0;
      t.kind = K_GRANT;
      if (j == ab_idx) begin
        t.kind = K_ABORT;
        fin    = 1;
      end else if (j == to_idx) begin
        t.kind = K_TMO;
        t.hold = 16;
        fin    = 1;
      end
      q.push_back(t);
    end
    if (!fin) begin
      t.kind = K_DONE;
      t.val  = '0;
      t.hold = !all_acc ? -1 : (n == 0 ? 0 : n + stall0);
      q.push_back(t);
    end
    @(negedge clk);
    bus.start    = 1'b1;
    bus.req_mask = mask;
    bus.abort    = 1'($urandom_range(0, 1));
    bus.accept   = 1'b0;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.req_mask = $urandom;
    k    = 0;
    st   = 0;
    lows = 0;
    cyc  = 0;
    while (bus.busy && cyc < 300) begin
      bus.accept = 1'b0;
      bus.abort  = 1'b0;
      bus.start  = 1'b0;
      if (bus.grant_valid) begin
        if (k == ab_idx) begin
          bus.abort  = 1'b1;
          bus.accept = ab_acc;
        end else if (k == to_idx) begin
          bus.accept = 1'b0;
        end else if (k == 0 && st < stall0) begin
          st++;
          if (poke && st == 2) begin
            bus.start    = 1'b1;
            bus.req_mask = $urandom;
          end
        end else if (all_acc || lows >= 8 ||
                     $urandom_range(0, 2) != 0) begin
          bus.accept = 1'b1;
          lows = 0;
          k++;
        end else begin
          lows++;
        end
      end else begin
        bus.accept = 1'($urandom_range(0, 1));
        bus.abort  = bus.done && ($urandom_range(0, 1) == 1);
      end
      cyc++;
      @(negedge clk);
    end
    bus.accept = 1'b0;
    bus.abort  = 1'b0;
    bus.start  = 1'b0;
    chk("seq_end", 64'(cyc < 300), 1);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start  = 1'b0;
      bus.accept = 1'($urandom_range(0, 1));
      bus.abort  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic reset_mid();
    tok_t t;
    t.kind = K_GRANT;
    t.val  = 32'h0000_0010;
    t.hold = 0;
    q.push_back(t);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.req_mask = 32'h0000_00F0;
    bus.abort    = 1'b0;
    bus.accept   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_reset_gv", bus.grant_valid, 1);
    #2 clr_n = 1'b0;
    #2;
    chk("rst_grant", bus.grant_onehot, 0);
    chk("rst_gv", bus.grant_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.timeout_err, 0);
    q.delete();
    exp_tmo = 0;
    @(negedge clk);
    @(negedge clk);
    #2 clr_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_busy", bus.busy, 0);
  endtask

  initial begin : driver
    logic [W-1:0] m;
    n_cmp        = 0;
    n_bad        = 0;
    exp_tmo      = 0;
    clr_n        = 1'b0;
    bus.start    = 1'b0;
    bus.req_mask = '0;
    bus.abort    = 1'b0;
    bus.accept   = 1'b0;
    #1;
    chk("init_grant", bus.grant_onehot, 0);
    chk("init_gv", bus.grant_valid, 0);
    chk("init_busy", bus.busy, 0);
    chk("init_done", bus.done, 0);
    chk("init_err", bus.timeout_err, 0);
    repeat (2) @(negedge clk);
    #2 clr_n = 1'b1;

    run_seq(32'h8000_0005, 1, 0, 0, -1, 0, -1);
    idle(2);
    run_seq(32'h0000_0300, 1, 5, 1, -1, 0, -1);
    run_seq(32'h0000_0000, 1, 0, 0, -1, 0, -1);
    run_seq(32'hFFFF_FFFF, 1, 0, 0, -1, 0, -1);
    run_seq(32'h0000_0007, 1, 0, 0, 1, 1, -1);
    idle(3);
`ifdef GRANT_TIMEOUT_EN
    run_seq(32'h0000_0C00, 1, 0, 0, -1, 0, 1);
    idle(2);
    run_seq(32'h0000_0011, 1, 0, 0, -1, 0, -1);
`else
    run_seq(32'h0000_0300, 1, 20, 0, -1, 0, -1);
`endif

    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) m = '0;
      else m = $urandom & $urandom & $urandom;
      run_seq(m, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ?
                int'($urandom_range(0, 3)) : -1,
              1'($urandom_range(0, 1)), -1);
      idle(int'($urandom_range(0, 2)));
    end

    reset_mid();
    run_seq(32'h0000_00F0, 0, 1, 0, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_grant_sequencer.md
Name: bus_grant_sequencer

Overview:
- Upstream feeder of the 32-to-5 bus-select encoder.
- Takes a multi-bit request mask of bus sources, e.g. a register-list transfer or debug dump.
- Presents exactly one source at a time as a clean one-hot grant, lowest index first, and advances on each consumer accept.
- Guarantees that the encoder never sees a multi-hot word, and sees a zero word only while grant_valid is low.

Parameters:
- WIDTH, 32: number of bus sources. Must equal the encoder input width.
- TIMEOUT_CYCLES, 16: maximum cycles a grant may wait for accept. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  single system clock, rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a sequence; sampled only in IDLE.
- req_mask  in  WIDTH  sources to grant; latched on an accepted start.
- abort  in  1  synchronous cancel of the sequence in progress.
- accept  in  1  consumer has taken the current grant.
- grant_onehot  out  WIDTH  one-hot bus-drive select; all zero when grant_valid is 0.
- grant_valid  out  1  grant_onehot is meaningful.
- busy  out  1  high in GRANT and DONE.
- done  out  1  one-cycle pulse at sequence end.
- timeout_err  out  1  sticky error flag; constant 0 when the optional feature is excluded.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - state=IDLE; pending mask=0.
  - grant_onehot=0, grant_valid=0, busy=0, done=0, timeout_err=0.
  - Reset asserted mid-sequence discards the sequence immediately, with no done pulse.
- States: IDLE, GRANT, DONE. Encoded as registered state; all outputs are registered or decoded from registers only, with no combinational path from inputs.
- IDLE:
  - start=1 with req_mask≠0: pending<=req_mask, next state GRANT. grant_valid rises on the following cycle (1-cycle latency).
  - start=1 with req_mask=0: next state DONE. No grant is ever issued.
  - start=0: stay in IDLE.
- GRANT:
  - grant_onehot = lowest set bit of pending (pending & -pending); grant_valid=1.
  - accept=1: clear that bit in pending at the clock edge.
    - If bits remain, the next grant appears on the very next cycle. Back-to-back accepts therefore yield one grant per cycle.
    - If none remain, next state DONE.
  - accept=0: hold the grant unchanged indefinitely (unless the optional feature is compiled in).
- DONE:
  - done=1 and busy=1 for exactly one cycle; grant_valid=0.
  - Next state is IDLE.
- Ignored inputs:
  - start is ignored when not in IDLE; the new mask is not latched and the current sequence is unaffected.
  - accept is ignored when grant_valid=0.
- abort:
  - In GRANT: pending<=0, next state IDLE. No done pulse. abort has priority over a simultaneous accept.
  - In IDLE or DONE: no effect. DONE still completes.
- Simultaneous start and abort in IDLE: start wins.
- A mask with all WIDTH bits set grants bit 0 through bit WIDTH-1 in order, WIDTH grants total, then DONE. No wrap-around.
- timeout_err is cleared only by reset.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - A wait counter resets on each new grant and increments each GRANT cycle with accept=0.
  - When the counter reaches TIMEOUT_CYCLES, the block sets timeout_err=1 (sticky), clears pending, and goes to IDLE with no done pulse.
  - accept in the same cycle the counter reaches the limit takes priority: the grant completes normally.
- Undefined: no counter is built; timeout_err is tied to 0 and grants wait forever.

Test Plan:
- Reset check: drive clr_n low mid-GRANT with req_mask=32'h0000_00F0 in progress → all outputs 0 asynchronously; after release, state is IDLE with no done pulse.
- Back-to-back sequence: start with req_mask=32'h8000_0005 and accept held high → grants 32'h1, then 32'h4, then 32'h8000_0000 on consecutive cycles, grant_valid high exactly 3 cycles, done pulses once on the following cycle.
- Stall: req_mask=32'h0000_0300 with accept low for 5 cycles → grant_onehot stays 32'h100 throughout; after accept it changes to 32'h200. Also confirm a start pulsed during the stall is ignored.
- Empty and full masks: req_mask=0 → done one cycle after start with grant_valid never high. req_mask=32'hFFFF_FFFF with accept held → 32 grants in ascending order, each strictly one-hot.
- Abort with accept: abort and accept together on the second grant of req_mask=32'h0000_0007 → state IDLE, no done pulse, no further grants.
- Timeout (GRANT_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): hold accept low → timeout_err rises after 16 waiting cycles and stays high across a subsequent normal sequence. With the macro undefined, timeout_err stays 0.
